fir_param: RTL and testbench

- Parametrised streaming FIR filter; next generation of the fixed 32-bit `fir` core.
- Adds generics for tap count, data width and coefficient width.
- Adds a runtime-writable coefficient bank, input/output valid qualifiers, rounding shift, saturate-or-wrap output mode and a synchronous flush.
- Sits between the sample source and the error/trace logic in the dafir benchmark, one sample per clock.

---
 rtl/fir_param_pkg.sv | 23 ++
 rtl/fir_round_sat.sv | 39 +++
 rtl/fir_param.sv | 108 ++++++++++
 tb/tb_fir_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_param_pkg.sv
// Shared constants and width helpers for the parametrised FIR filter.
package fir_param_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  function automatic int unsigned clog2_u(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

  // Signed accumulator wide enough that summing every tap product cannot overflow.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + 1 + coef_w + clog2_u(taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up right shift followed by saturate or wrap to OUT_W bits.
module fir_round_sat
  import fir_param_pkg::*;
#(
  parameter int unsigned ACC_W = 51,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned SAT   = MODE_SAT
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [OUT_W-1:0] res_o
);

  // One bit of headroom over both the accumulator and the output width keeps the
  // rounding add and the upper-bound compare exact.
  localparam int unsigned EXT_W = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] r_ext;

  always_comb acc_ext = {{(EXT_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};

  if (SHIFT > 0) begin : g_round
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (SHIFT - 1);
    always_comb r_ext = (acc_ext + HALF) >>> SHIFT;
  end else begin : g_pass
    always_comb r_ext = acc_ext;
  end

  always_comb begin
    res_o = r_ext[OUT_W-1:0];
    if (SAT == MODE_SAT) begin
      if (r_ext[EXT_W-1])      res_o = '0;
      else if (r_ext > MAX_V)  res_o = '1;
    end
  end

endmodule

// File: rtl/fir_param.sv
// Streaming FIR: delay line and writable coefficient bank, registered MAC, registered round/saturate.
module fir_param
  import fir_param_pkg::*;
#(
  parameter int unsigned TAPS   = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned SAT    = MODE_SAT
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          Data_in,
  input  logic                       flush,
  input  logic                       coef_we,
  input  logic [clog2_u(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           Data_out
);

  localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  logic [DATA_W-1:0]        tap_q  [TAPS];
  logic [DATA_W-1:0]        tap_d  [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  mac_sum, prod;
  logic                     v0_q, v0_d, v1_q, v1_d, ov_q, ov_d;
  logic [OUT_W-1:0]         dout_q, dout_d;
  logic [OUT_W-1:0]         round_res;
  logic                     coef_hit;

  // Taps are zero-extended so unsigned samples multiply correctly against signed coefficients.
  always_comb begin
    mac_sum = '0;
    prod    = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      prod    = ACC_W'($signed({1'b0, tap_q[k]})) * ACC_W'(coef_q[k]);
      mac_sum = mac_sum + prod;
    end
  end

  always_comb coef_hit = coef_we && (32'(coef_addr) < TAPS);

  always_comb begin
    tap_d  = tap_q;
    coef_d = coef_q;
    v0_d   = 1'b0;
    v1_d   = v0_q;
    ov_d   = v1_q;
    acc_d  = mac_sum;
    dout_d = v1_q ? round_res : dout_q;
    if (coef_hit) coef_d[coef_addr] = coef_data;
    if (flush) begin
      for (int unsigned k = 0; k < TAPS; k++) tap_d[k] = '0;
      v1_d   = 1'b0;
      ov_d   = 1'b0;
      acc_d  = '0;
      dout_d = dout_q;
    end else if (in_valid) begin
      for (int unsigned k = TAPS - 1; k > 0; k--) tap_d[k] = tap_q[k-1];
      tap_d[0] = Data_in;
      v0_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        tap_q[k]  <= '0;
        coef_q[k] <= '0;
      end
      acc_q  <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      ov_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      tap_q  <= tap_d;
      coef_q <= coef_d;
      acc_q  <= acc_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      ov_q   <= ov_d;
      dout_q <= dout_d;
    end
  end

  fir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .SAT   (SAT)
  ) u_round_sat (
    .acc_i (acc_q),
    .res_o (round_res)
  );

  always_comb begin
    out_valid = ov_q;
    Data_out  = dout_q;
  end

endmodule

// File: tb/tb_fir_param.sv
// Scoreboard bench: three filter variants share one stimulus stream and one arithmetic reference model.
module tb_fir_param;
  import fir_param_pkg::*;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    int               due;
    logic [2:0][31:0] v;
  } exp_t;

  logic        clk       = 1'b0;
  logic        Reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic [31:0] data_in   = '0;
  logic        flush     = 1'b0;
  logic        coef_we   = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;

  logic             ov0, ov1, ov2;
  logic [31:0]      d0, d1, d2;
  logic [2:0]       ov;
  logic [2:0][31:0] dout;

  assign ov   = {ov2, ov1, ov0};
  assign dout = {d2, d1, d0};

  // Variant 0: SHIFT=0 saturate; variant 1: SHIFT=2 saturate; variant 2: SHIFT=0 wrap.
  fir_param #(.TAPS(4), .DATA_W(32), .COEF_W(16), .OUT_W(32), .SHIFT(0), .SAT(MODE_SAT)) u_dut0 (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .Data_in(data_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov0), .Data_out(d0));
  fir_param #(.TAPS(4), .DATA_W(32), .COEF_W(16), .OUT_W(32), .SHIFT(2), .SAT(MODE_SAT)) u_dut1 (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .Data_in(data_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov1), .Data_out(d1));
  fir_param #(.TAPS(4), .DATA_W(32), .COEF_W(16), .OUT_W(32), .SHIFT(0), .SAT(MODE_WRAP)) u_dut2 (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .Data_in(data_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov2), .Data_out(d2));

  always #5 clk = ~clk;

  int          edge_n = 0;
  int          tests  = 0;
  int          fails  = 0;
  longint      hist [4];
  int          mcoef [4];
  exp_t        sbq [$];
  logic [31:0] last_exp [3];
  wq_t         seen0, seen1, seen2;
  wq_t         want_q;
  logic        exp_v;
  logic [31:0] want;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [31:0] ref_out(input longint acc, input int shift, input int sat);
    longint r;
    r = acc;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    if (sat != 0) begin
      if (r < 0) return 32'd0;
      if (r > 64'sd4294967295) return 32'hFFFF_FFFF;
    end
    return r[31:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      hist[k]  = 0;
      mcoef[k] = 0;
    end
    for (int g = 0; g < 3; g++) last_exp[g] = '0;
    sbq.delete();
  endtask

  // Drive one clock's inputs and advance the reference model to the coming edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic fl,
                      input logic we, input logic [1:0] a, input logic [15:0] c);
    int     e;
    longint acc;
    exp_t   ent;
    @(negedge clk);
    in_valid = iv; data_in = d; flush = fl;
    coef_we = we; coef_addr = a; coef_data = c;
    e = edge_n + 1;
    if (we) mcoef[a] = int'($signed(c));
    if (fl) begin
      for (int k = 0; k < 4; k++) hist[k] = 0;
      while (sbq.size() > 0 && sbq[$].due >= e) void'(sbq.pop_back());
    end else if (iv) begin
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'(d);
      acc = 0;
      for (int k = 0; k < 4; k++) acc += hist[k] * longint'(mcoef[k]);
      ent.due  = e + 2;
      ent.v[0] = ref_out(acc, 0, 1);
      ent.v[1] = ref_out(acc, 2, 1);
      ent.v[2] = ref_out(acc, 0, 0);
      sbq.push_back(ent);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic wr_coefs(input int c0, input int c1, input int c2, input int c3);
    step(1'b0, 32'd0, 1'b0, 1'b1, 2'd0, 16'(c0));
    step(1'b0, 32'd0, 1'b0, 1'b1, 2'd1, 16'(c1));
    step(1'b0, 32'd0, 1'b0, 1'b1, 2'd2, 16'(c2));
    step(1'b0, 32'd0, 1'b0, 1'b1, 2'd3, 16'(c3));
  endtask

  task automatic clear_seen();
    seen0.delete(); seen1.delete(); seen2.delete();
  endtask

  task automatic check_seen(input string name, input wq_t got, input wq_t exp);
    tests++;
    if (got.size() != exp.size()) begin
      fails++;
      $display("FAIL %s count got=%0d want=%0d", name, got.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        tests++;
        if (got[i] !== exp[i]) begin
          fails++;
          $display("FAIL %s[%0d] got=%h want=%h", name, i, got[i], exp[i]);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge Reset);
      #1;
      if (!Reset) begin
        for (int g = 0; g < 3; g++) begin
          tests++;
          if (ov[g] !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid dut%0d got=%0b want=0", g, ov[g]);
          end
          tests++;
          if (dout[g] !== 32'd0) begin
            fails++;
            $display("FAIL reset_data dut%0d got=%h want=0", g, dout[g]);
          end
        end
      end else begin
        exp_v = (sbq.size() > 0) && (sbq[0].due == edge_n);
        for (int g = 0; g < 3; g++) begin
          tests++;
          if (ov[g] !== exp_v) begin
            fails++;
            $display("FAIL valid dut%0d edge%0d got=%0b want=%0b", g, edge_n, ov[g], exp_v);
          end
          want = exp_v ? sbq[0].v[g] : last_exp[g];
          tests++;
          if (dout[g] !== want) begin
            fails++;
            $display("FAIL data dut%0d edge%0d got=%h want=%h", g, edge_n, dout[g], want);
          end
          if (exp_v) begin
            last_exp[g] = want;
            if (g == 0) seen0.push_back(dout[g]);
            if (g == 1) seen1.push_back(dout[g]);
            if (g == 2) seen2.push_back(dout[g]);
          end
        end
        if (exp_v) void'(sbq.pop_front());
        else if (sbq.size() > 0 && sbq[0].due < edge_n) begin
          tests++; fails++;
          $display("FAIL missing edge%0d due=%0d", edge_n, sbq[0].due);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #2 Reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    idle(2);

    wr_coefs(1, 2, 3, 4);
    clear_seen();
    step(1'b1, 32'd1, 1'b0, 1'b0, 2'd0, 16'd0);
    repeat (4) step(1'b1, 32'd0, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(4);
    want_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    check_seen("impulse", seen0, want_q);

    wr_coefs(1, 0, 0, 0);
    clear_seen();
    step(1'b1, 32'd6, 1'b0, 1'b0, 2'd0, 16'd0);
    step(1'b1, 32'd5, 1'b0, 1'b0, 2'd0, 16'd0);
    step(1'b1, 32'd2, 1'b0, 1'b0, 2'd0, 16'd0);
    step(1'b1, 32'd1, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(4);
    want_q = '{32'd2, 32'd1, 32'd1, 32'd0};
    check_seen("round", seen1, want_q);

    wr_coefs(-1, 0, 0, 0);
    clear_seen();
    step(1'b1, 32'd5, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(4);
    want_q = '{32'd0};
    check_seen("sat_neg", seen0, want_q);
    want_q = '{32'hFFFF_FFFB};
    check_seen("wrap_neg", seen2, want_q);

    wr_coefs(2, 0, 0, 0);
    clear_seen();
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(4);
    want_q = '{32'hFFFF_FFFF};
    check_seen("sat_pos", seen0, want_q);
    want_q = '{32'hFFFF_FFFE};
    check_seen("wrap_pos", seen2, want_q);

    wr_coefs(1, 1, 1, 1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 16'd0);
    clear_seen();
    step(1'b1, 32'd10, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(1);
    step(1'b1, 32'd20, 1'b0, 1'b0, 2'd0, 16'd0);
    step(1'b1, 32'd30, 1'b0, 1'b1, 2'd3, 16'd0);
    idle(4);
    want_q = '{32'd10, 32'd30, 32'd60};
    check_seen("gap_coef", seen0, want_q);

    step(1'b0, 32'd0, 1'b0, 1'b1, 2'd3, 16'd1);
    clear_seen();
    repeat (3) step(1'b1, 32'd7, 1'b0, 1'b0, 2'd0, 16'd0);
    step(1'b1, 32'd9, 1'b1, 1'b0, 2'd0, 16'd0);
    idle(5);
    step(1'b1, 32'd1, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(4);
    want_q = '{32'd67, 32'd1};
    check_seen("flush", seen0, want_q);

    step(1'b1, 32'd5, 1'b0, 1'b0, 2'd0, 16'd0);
    step(1'b1, 32'd6, 1'b0, 1'b0, 2'd0, 16'd0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    Reset    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    clear_seen();
    idle(4);
    step(1'b1, 32'd1, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(4);
    want_q = '{32'd0};
    check_seen("post_reset", seen0, want_q);

    wr_coefs(3, -2, 5, 1);
    repeat (400) begin
      step(($urandom % 4) != 0,
           (($urandom % 3) == 0) ? 32'($urandom) : 32'($urandom % 1000),
           ($urandom % 25) == 0,
           ($urandom % 5) == 0,
           2'($urandom % 4),
           16'($urandom));
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
